// File: rtl/turnstile_fare_controller.sv
// Turnstile fare controller.
// Collects coin credit until the fare is reached, then unlocks the gate for one
// passage. Overpayment, cancellation and unlock timeout are returned through a
// one-cycle refund pulse. Every output is registered.
//
// Build option: define TURNSTILE_PASS_COUNTER_EN to build the passage counter.
// If the macro is not defined, o_Pass_Count is tied to zero and the port list
// stays the same.
module turnstile_fare_controller #(
    parameter int FARE           = 4,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic        i_Coin_Valid,
    input  logic [3:0]  i_Coin_Value,
    input  logic        i_Push,
    input  logic        i_Cancel,
    output logic        o_Locked,
    output logic [7:0]  o_Credit,
    output logic        o_Coin_Reject,
    output logic        o_Refund_Valid,
    output logic [7:0]  o_Refund_Value,
    output logic [15:0] o_Pass_Count
);

    localparam int              TMR_W      = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [8:0]      FARE_SUM   = 9'(FARE);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        UNLOCKED = 2'd2,
        REFUND   = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       change, change_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [7:0]       credit_nxt;
    logic             locked_nxt;
    logic             reject_nxt;
    logic             refund_valid_nxt;
    logic [7:0]       refund_value_nxt;
    logic             coin_live;
    logic [8:0]       coin_sum;
`ifdef TURNSTILE_PASS_COUNTER_EN
    logic             pass_inc;
`endif

    // The credit register can hold at most 255, so a larger total is clamped.
    function automatic logic [7:0] sat8(input logic [8:0] v);
        return v[8] ? 8'hFF : v[7:0];
    endfunction

    // A coin of value zero does nothing and is not rejected.
    assign coin_live = i_Coin_Valid && (i_Coin_Value != 4'd0);
    assign coin_sum  = {1'b0, o_Credit} + {5'd0, i_Coin_Value};

    // State register
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) state <= IDLE;
        else          state <= state_nxt;
    end

    // Credit, change, timer and the registered outputs
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Locked       <= 1'b1;
            o_Credit       <= 8'd0;
            change         <= 8'd0;
            timer          <= '0;
            o_Coin_Reject  <= 1'b0;
            o_Refund_Valid <= 1'b0;
            o_Refund_Value <= 8'd0;
        end else begin
            o_Locked       <= locked_nxt;
            o_Credit       <= credit_nxt;
            change         <= change_nxt;
            timer          <= timer_nxt;
            o_Coin_Reject  <= reject_nxt;
            o_Refund_Valid <= refund_valid_nxt;
            o_Refund_Value <= refund_value_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt        = state;
        credit_nxt       = o_Credit;
        change_nxt       = change;
        timer_nxt        = timer;
        reject_nxt       = 1'b0;
        refund_valid_nxt = 1'b0;
        refund_value_nxt = 8'd0;
`ifdef TURNSTILE_PASS_COUNTER_EN
        pass_inc         = 1'b0;
`endif
        case (state)
            IDLE, COLLECT: begin
                if ((state == COLLECT) && i_Cancel) begin
                    // A cancel takes priority over a coin in the same cycle.
                    // That coin is returned and the refund is the credit held
                    // before this cycle.
                    state_nxt        = REFUND;
                    refund_valid_nxt = 1'b1;
                    refund_value_nxt = o_Credit;
                    credit_nxt       = 8'd0;
                    change_nxt       = 8'd0;
                    reject_nxt       = coin_live;
                end else if (coin_live) begin
                    if (coin_sum < FARE_SUM) begin
                        state_nxt  = COLLECT;
                        credit_nxt = coin_sum[7:0];
                    end else begin
                        state_nxt  = UNLOCKED;
                        credit_nxt = sat8(coin_sum);
                        change_nxt = sat8(coin_sum - FARE_SUM);
                        timer_nxt  = '0;
                    end
                end
            end
            UNLOCKED: begin
                reject_nxt = coin_live;
                timer_nxt  = timer + 1'b1;
                if (i_Push) begin
                    // A push takes priority over a timeout in the same cycle.
                    // Leaving this state right away means a held push counts once.
`ifdef TURNSTILE_PASS_COUNTER_EN
                    pass_inc   = 1'b1;
`endif
                    credit_nxt = 8'd0;
                    change_nxt = 8'd0;
                    timer_nxt  = '0;
                    if (change != 8'd0) begin
                        state_nxt        = REFUND;
                        refund_valid_nxt = 1'b1;
                        refund_value_nxt = change;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (timer == TIMER_LAST) begin
                    state_nxt        = REFUND;
                    refund_valid_nxt = 1'b1;
                    refund_value_nxt = o_Credit;
                    credit_nxt       = 8'd0;
                    change_nxt       = 8'd0;
                    timer_nxt        = '0;
                end
            end
            REFUND: begin
                reject_nxt = coin_live;
                state_nxt  = IDLE;
                credit_nxt = 8'd0;
                change_nxt = 8'd0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        locked_nxt = (state_nxt != UNLOCKED);
    end

`ifdef TURNSTILE_PASS_COUNTER_EN
    // Passage counter; it wraps from 65535 to 0
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L)      o_Pass_Count <= 16'd0;
        else if (pass_inc) o_Pass_Count <= o_Pass_Count + 16'd1;
    end
`else
    assign o_Pass_Count = 16'd0;
`endif

endmodule

// File: tb/tb_turnstile_fare_controller.sv
// Directed bench for turnstile_fare_controller with FARE=4 and TIMEOUT_CYCLES=10.
module tb_turnstile_fare_controller;

`ifdef TURNSTILE_PASS_COUNTER_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        coin_valid = 1'b0;
    logic [3:0]  coin_value = 4'd0;
    logic        push = 1'b0;
    logic        cancel = 1'b0;
    logic        locked;
    logic [7:0]  credit;
    logic        coin_reject;
    logic        refund_valid;
    logic [7:0]  refund_value;
    logic [15:0] pass_count;

    int passed = 0;
    int total  = 0;

    turnstile_fare_controller #(.FARE(4), .TIMEOUT_CYCLES(10)) dut (
        .i_Clk          (clk),
        .i_Rst_L        (rst_n),
        .i_Coin_Valid   (coin_valid),
        .i_Coin_Value   (coin_value),
        .i_Push         (push),
        .i_Cancel       (cancel),
        .o_Locked       (locked),
        .o_Credit       (credit),
        .o_Coin_Reject  (coin_reject),
        .o_Refund_Valid (refund_valid),
        .o_Refund_Value (refund_value),
        .o_Pass_Count   (pass_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic coin(input logic [3:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        tick();
        coin_valid = 1'b0;
        coin_value = 4'd0;
    endtask

    task automatic idle_outputs(input string tag, input int cnt);
        chk({tag, "_locked"}, locked, 1);
        chk({tag, "_credit"}, credit, 0);
        chk({tag, "_reject"}, coin_reject, 0);
        chk({tag, "_rvalid"}, refund_valid, 0);
        chk({tag, "_rvalue"}, refund_value, 0);
        chk({tag, "_count"}, pass_count, CNT_EN * cnt);
    endtask

    initial begin
        // Reset state
        tick();
        idle_outputs("rst", 0);
        rst_n = 1'b1;
        tick();
        idle_outputs("post_rst", 0);

        // A zero-value coin and a cancel in IDLE both do nothing
        coin(4'd0);
        idle_outputs("zero_coin", 0);
        cancel = 1'b1; tick(); cancel = 1'b0;
        idle_outputs("idle_cancel", 0);

        // Exact fare paid with four 1-unit coins
        coin(4'd1); chk("c1_credit", credit, 1); chk("c1_locked", locked, 1);
        coin(4'd1); chk("c2_credit", credit, 2);
        coin(4'd1); chk("c3_credit", credit, 3); chk("c3_locked", locked, 1);
        coin(4'd1); chk("c4_locked", locked, 0); chk("c4_credit", credit, 4);
        push = 1'b1;
        tick();
        idle_outputs("push1", 1);
        tick();  // push still held, now in IDLE
        tick();
        idle_outputs("held_push", 1);
        push = 1'b0;

        // Overpayment: the change of 2 is refunded after the push
        coin(4'd3); chk("o1_credit", credit, 3);
        coin(4'd3); chk("o2_locked", locked, 0); chk("o2_credit", credit, 6);
        push = 1'b1; tick(); push = 1'b0;
        chk("chg_rvalid", refund_valid, 1);
        chk("chg_rvalue", refund_value, 2);
        chk("chg_locked", locked, 1);
        chk("chg_count", pass_count, CNT_EN * 2);
        tick();
        idle_outputs("chg_done", 2);

        // Cancel and coin in the same cycle: cancel wins and the coin is rejected
        coin(4'd2); chk("cx_credit", credit, 2);
        cancel = 1'b1; coin(4'd1); cancel = 1'b0;
        chk("cx_reject", coin_reject, 1);
        chk("cx_rvalid", refund_valid, 1);
        chk("cx_rvalue", refund_value, 2);
        chk("cx_credit0", credit, 0);
        tick();
        idle_outputs("cx_done", 2);

        // Timeout with no push: the full credit is refunded
        coin(4'd5); chk("to_locked", locked, 0); chk("to_credit", credit, 5);
        repeat (9) tick();
        chk("to_last_locked", locked, 0);
        chk("to_last_rvalid", refund_valid, 0);
        tick();
        chk("to_rvalid", refund_valid, 1);
        chk("to_rvalue", refund_value, 5);
        chk("to_locked_hi", locked, 1);
        tick();
        idle_outputs("to_done", 2);

        // Push and timeout in the same cycle: the push wins
        coin(4'd5);
        repeat (9) tick();
        push = 1'b1; tick(); push = 1'b0;
        chk("pt_rvalid", refund_valid, 1);
        chk("pt_rvalue", refund_value, 1);
        chk("pt_count", pass_count, CNT_EN * 3);
        tick();
        idle_outputs("pt_done", 3);

        // Reset during collection discards the credit and gives no refund
        coin(4'd3); chk("rc_credit", credit, 3);
        rst_n = 1'b0;
        #1;
        idle_outputs("rc_async", 0);
        tick();
        rst_n = 1'b1;
        tick();
        idle_outputs("rc_after", 0);

        // A coin while unlocked is rejected and the credit is unchanged
        coin(4'd4); chk("ul_locked", locked, 0);
        coin(4'd2);
        chk("ul_reject", coin_reject, 1);
        chk("ul_credit", credit, 4);
        chk("ul_locked2", locked, 0);
        tick();
        chk("ul_reject_clr", coin_reject, 0);
        chk("ul_credit2", credit, 4);

        // Reset while unlocked
        rst_n = 1'b0;
        #1;
        idle_outputs("ru_async", 0);
        tick();
        rst_n = 1'b1;
        tick();
        idle_outputs("ru_after", 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/turnstile_fare_controller.md
TURNSTILE_FARE_CONTROLLER -- requirements
Module: turnstile_fare_controller

Interface
REQ-001 SHALL have parameter FARE, default 4, credit units required to unlock one passage (1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000, clock cycles a paid gate stays unlocked awaiting a push (>=2).
REQ-003 SHALL have port i_Clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port i_Rst_L  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_Coin_Valid  input  1  one-cycle strobe, coin accepted by acceptor.
REQ-006 SHALL have port i_Coin_Value  input  4  coin value in credit units, sampled with i_Coin_Valid.
REQ-007 SHALL have port i_Push  input  1  passage sensor, high for at least one cycle per passage.
REQ-008 SHALL have port i_Cancel  input  1  one-cycle strobe, patron requests refund.
REQ-009 SHALL have port o_Locked  output  1  high when gate locked.
REQ-010 SHALL have port o_Credit  output  8  current accumulated credit.
REQ-011 SHALL have port o_Coin_Reject  output  1  one-cycle pulse, last sampled coin returned uncredited.
REQ-012 SHALL have port o_Refund_Valid  output  1  one-cycle pulse, dispense o_Refund_Value.
REQ-013 SHALL have port o_Refund_Value  output  8  refund amount, valid only with o_Refund_Valid, else 0.
REQ-014 SHALL have port o_Pass_Count  output  16  completed passages.

Function
REQ-015 SHALL implement states IDLE, COLLECT, UNLOCKED, REFUND; all outputs registered.
REQ-016 IDLE/COLLECT, coin with credit+value < FARE: credit += value, next state COLLECT, visible on o_Credit next cycle.
REQ-017 IDLE/COLLECT, coin with credit+value >= FARE: next state UNLOCKED, credit <= credit+value, change <= credit+value-FARE; o_Locked low the cycle after the coin strobe.
REQ-018 Coin with i_Coin_Value==0 SHALL be ignored with no reject pulse.
REQ-019 Coin arriving in UNLOCKED or REFUND SHALL not change credit; o_Coin_Reject pulses next cycle.
REQ-020 COLLECT, i_Cancel: next state REFUND, refund value = credit; cancel in IDLE/UNLOCKED/REFUND ignored.
REQ-021 COLLECT, i_Cancel and i_Coin_Valid same cycle: cancel wins, coin rejected (o_Coin_Reject), refund = prior credit.
REQ-022 UNLOCKED: timer starts at 0 on entry, increments each cycle.
REQ-023 UNLOCKED, i_Push: o_Pass_Count += 1 (wrap 65535->0); next state REFUND with value = change if change>0, else IDLE with credit 0.
REQ-024 UNLOCKED, timer == TIMEOUT_CYCLES-1 without push: next state REFUND, value = full credit (fare plus change).
REQ-025 UNLOCKED, push and timeout same cycle: push wins.
REQ-026 REFUND: exactly one cycle; o_Refund_Valid=1 with value; credit cleared; next state IDLE, o_Locked high.
REQ-027 i_Push outside UNLOCKED SHALL have no effect; a held i_Push SHALL count once per unlock.

Reset
REQ-028 i_Rst_L low SHALL immediately force IDLE, o_Locked=1, o_Credit=0, change=0, timer=0, o_Coin_Reject=0, o_Refund_Valid=0, o_Refund_Value=0, o_Pass_Count=0.
REQ-029 Reset mid-collection or while unlocked SHALL discard credit with no refund pulse.

Configuration
REQ-030 Macro TURNSTILE_PASS_COUNTER_EN defined: o_Pass_Count behaves per REQ-023.
REQ-031 Macro TURNSTILE_PASS_COUNTER_EN undefined: counter not built, o_Pass_Count constant 0; port list unchanged.

Verification
REQ-032 Reset, coins 1,1,1,1 (FARE=4) -> o_Credit 1,2,3; o_Locked low after 4th; push -> locked, count=1, no refund.
REQ-033 Coin 3 then coin 3 -> unlock, push -> o_Refund_Valid one cycle with value 2, then IDLE.
REQ-034 Coin 2, then cancel+coin 1 same cycle -> o_Coin_Reject pulse, refund 2, credit 0.
REQ-035 Coin 5, no push for TIMEOUT_CYCLES (=10) -> refund 5, o_Locked high; push with timeout same cycle -> refund 1, count increments.
REQ-036 Coin 3 then i_Rst_L low mid-collect -> o_Credit 0, locked, no refund; coin in UNLOCKED -> reject, credit unchanged.
